// File: rtl/pipeline_stage_latches.sv
// pipeline_stage_latches: FD, DX and MW pipeline boundary registers with independent write enables
module pipeline_stage_latches #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fd_en,
  input  logic [WIDTH-1:0] fd_ir_in,
  input  logic [WIDTH-1:0] fd_pc_in,
  output logic [WIDTH-1:0] fd_ir_out,
  output logic [WIDTH-1:0] fd_pc_out,
  input  logic             dx_en,
  input  logic [WIDTH-1:0] dx_ir_in,
  input  logic [WIDTH-1:0] dx_pc_in,
  input  logic [WIDTH-1:0] dx_a_in,
  input  logic [WIDTH-1:0] dx_b_in,
  output logic [WIDTH-1:0] dx_ir_out,
  output logic [WIDTH-1:0] dx_pc_out,
  output logic [WIDTH-1:0] dx_a_out,
  output logic [WIDTH-1:0] dx_b_out,
  input  logic             mw_en,
  input  logic [WIDTH-1:0] mw_ir_in,
  input  logic [WIDTH-1:0] mw_pc_in,
  input  logic [WIDTH-1:0] mw_o_in,
  input  logic [WIDTH-1:0] mw_d_in,
  output logic [WIDTH-1:0] mw_ir_out,
  output logic [WIDTH-1:0] mw_pc_out,
  output logic [WIDTH-1:0] mw_o_out,
  output logic [WIDTH-1:0] mw_d_out
);
  always_ff @(posedge clock)
    if (reset) begin
      fd_ir_out <= NOP;
      fd_pc_out <= NOP;
    end else if (fd_en) begin
      fd_ir_out <= fd_ir_in;
      fd_pc_out <= fd_pc_in;
    end
  always_ff @(posedge clock)
    if (reset) begin
      dx_ir_out <= NOP;
      dx_pc_out <= NOP;
      dx_a_out  <= NOP;
      dx_b_out  <= NOP;
    end else if (dx_en) begin
      dx_ir_out <= dx_ir_in;
      dx_pc_out <= dx_pc_in;
      dx_a_out  <= dx_a_in;
      dx_b_out  <= dx_b_in;
    end
  always_ff @(posedge clock)
    if (reset) begin
      mw_ir_out <= NOP;
      mw_pc_out <= NOP;
      mw_o_out  <= NOP;
      mw_d_out  <= NOP;
    end else if (mw_en) begin
      mw_ir_out <= mw_ir_in;
      mw_pc_out <= mw_pc_in;
      mw_o_out  <= mw_o_in;
      mw_d_out  <= mw_d_in;
    end
endmodule

// File: tb/tb_pipeline_stage_latches.sv
// tb_pipeline_stage_latches: randomized and directed checks of the pipeline latches against a field-array model
module tb_pipeline_stage_latches;
  localparam int W = 32;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic fd_en = 1'b0;
  logic dx_en = 1'b0;
  logic mw_en = 1'b0;
  logic [W-1:0] in_v [10];
  logic [W-1:0] out_v [10];
  logic [W-1:0] model [10];
  int errs = 0;
  int checks = 0;
  always #5 clock = ~clock;
  pipeline_stage_latches #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .fd_en(fd_en), .fd_ir_in(in_v[0]), .fd_pc_in(in_v[1]),
    .fd_ir_out(out_v[0]), .fd_pc_out(out_v[1]),
    .dx_en(dx_en), .dx_ir_in(in_v[2]), .dx_pc_in(in_v[3]), .dx_a_in(in_v[4]), .dx_b_in(in_v[5]),
    .dx_ir_out(out_v[2]), .dx_pc_out(out_v[3]), .dx_a_out(out_v[4]), .dx_b_out(out_v[5]),
    .mw_en(mw_en), .mw_ir_in(in_v[6]), .mw_pc_in(in_v[7]), .mw_o_in(in_v[8]), .mw_d_in(in_v[9]),
    .mw_ir_out(out_v[6]), .mw_pc_out(out_v[7]), .mw_o_out(out_v[8]), .mw_d_out(out_v[9])
  );
  function automatic logic field_en(int i);
    return i < 2 ? fd_en : i < 6 ? dx_en : mw_en;
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    for (int i = 0; i < 10; i++) chk($sformatf("%s[%0d]", tag, i), out_v[i], model[i]);
  endtask
  task automatic step(input string tag);
    @(posedge clock);
    for (int i = 0; i < 10; i++) model[i] = reset ? '0 : field_en(i) ? in_v[i] : model[i];
    #1;
    check_all(tag);
  endtask
  task automatic drive_all(input logic [W-1:0] v);
    for (int i = 0; i < 10; i++) in_v[i] = v;
  endtask
  task automatic drive_rand();
    for (int i = 0; i < 10; i++) in_v[i] = $urandom;
    #1;
    check_all("no_comb_path");
  endtask
  initial begin
    drive_all(32'hDEADBEEF);
    reset = 1'b1;
    step("first_reset");
    reset = 1'b0;
    {fd_en, dx_en, mw_en} = 3'b111;
    step("preload");
    reset = 1'b1;
    step("reset_en1");
    chk("reset_en1_fd_ir", out_v[0], 32'h0);
    reset = 1'b0;
    step("preload2");
    {fd_en, dx_en, mw_en} = 3'b000;
    reset = 1'b1;
    step("reset_en0");
    chk("reset_en0_mw_d", out_v[9], 32'h0);
    reset = 1'b0;
    {fd_en, dx_en, mw_en} = 3'b111;
    in_v[0] = 32'h28000005; in_v[1] = 32'h00000010; in_v[2] = 32'h1; in_v[3] = 32'h2;
    in_v[4] = 32'h7; in_v[5] = 32'hFFFFFFF9; in_v[6] = 32'h3; in_v[7] = 32'h4;
    in_v[8] = 32'h5; in_v[9] = 32'h12345678;
    #1;
    check_all("load_before_edge");
    step("load");
    chk("load_dx_b", out_v[5], 32'hFFFFFFF9);
    chk("load_mw_d", out_v[9], 32'h12345678);
    in_v[0] = 32'h11111111; in_v[1] = 32'h3;
    step("stall_prep");
    fd_en = 1'b0;
    in_v[0] = 32'h22222222; in_v[2] = 32'h0;
    step("stall");
    chk("stall_fd_ir", out_v[0], 32'h11111111);
    chk("stall_fd_pc", out_v[1], 32'h3);
    chk("stall_bubble", out_v[2], 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive_rand();
      step("hold");
      chk("hold_fd_ir", out_v[0], 32'h11111111);
    end
    fd_en = 1'b1;
    drive_rand();
    step("reenable");
    {fd_en, dx_en} = 2'b00;
    for (int k = 0; k < 4; k++) begin
      mw_en = k[0];
      drive_rand();
      step("mw_only");
    end
    {fd_en, dx_en, mw_en} = 3'b111;
    in_v[0] = 32'hAAAAAAAA;
    step("stall2_prep");
    fd_en = 1'b0;
    drive_rand();
    step("stall2");
    chk("stall2_fd_ir", out_v[0], 32'hAAAAAAAA);
    reset = 1'b1;
    step("reset_mid_stall");
    chk("reset_mid_stall_fd_ir", out_v[0], 32'h0);
    reset = 1'b0;
    fd_en = 1'b1;
    in_v[0] = 32'h5;
    step("resume");
    chk("resume_fd_ir", out_v[0], 32'h5);
    for (int k = 0; k < 200; k++) begin
      reset = $urandom_range(0, 15) == 0;
      fd_en = $urandom_range(0, 1) == 1;
      dx_en = $urandom_range(0, 1) == 1;
      mw_en = $urandom_range(0, 1) == 1;
      drive_rand();
      step("random");
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
